i2s_source_sched: RTL and testbench

Sample-source scheduler for the I2S transmit subperipheral. On each frame request from the I2S transmitter it supplies one 32-bit stereo sample ({left[31:16], right[15:0]}). Samples come from one of two sources: an internal configurable square-tone source, or a CPU-fed stream FIFO. The block also handles underrun substitution and underrun counting.

---
 rtl/i2s_source_sched.sv | 143 ++++++++++++++
 tb/tb_i2s_source_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_source_sched.sv
// Sample-source scheduler for the I2S transmitter: picks silence, a square tone or
// a CPU-fed stream FIFO on each frame request, substituting on underrun.
module i2s_source_sched #(
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_mode,
  input  logic [23:0]             i_tone_half,
  input  logic [31:0]             i_tone_hi,
  input  logic [31:0]             i_tone_lo,
  input  logic                    i_s_valid,
  input  logic [31:0]             i_s_data,
  output logic                    o_s_ready,
  input  logic                    i_frame_req,
  output logic [31:0]             o_tx_data,
  output logic                    o_tx_valid,
  output logic [$clog2(DEPTH):0]  o_fifo_level,
  output logic [15:0]             o_underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Free-running tone generator
  logic [23:0] r_tcnt;
  logic        r_phase;
  logic [23:0] w_half;
  logic        w_wrap;
  logic [31:0] w_tone;

  assign w_half = (i_tone_half == 24'd0) ? 24'd1 : i_tone_half;
  // >= rather than == so a shrinking half-period wraps immediately
  assign w_wrap = (r_tcnt >= (w_half - 24'd1));
  assign w_tone = r_phase ? i_tone_lo : i_tone_hi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcnt  <= 24'd0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_tcnt  <= 24'd0;
      r_phase <= ~r_phase;
    end else begin
      r_tcnt  <= r_tcnt + 24'd1;
    end
  end

  // Stream FIFO
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_next;
  logic          r_s_ready;
  logic          w_flush;
  logic          w_stream;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_underrun;

  assign w_flush    = (i_mode == 2'd0);
  assign w_stream   = i_mode[1];
  assign w_empty    = (r_level == '0);
  assign w_push     = i_s_valid && r_s_ready && !w_flush && !i_rst;
  assign w_pop      = i_frame_req && w_stream && !w_empty;
  assign w_underrun = i_frame_req && w_stream && w_empty;

  always_comb begin
    w_level_next = r_level;
    if (w_flush) begin
      w_level_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_level_next = r_level + LVL_ONE;
        2'b01:   w_level_next = r_level - LVL_ONE;
        default: w_level_next = r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_ONE;
        if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      end
      r_level   <= w_level_next;
      r_s_ready <= (w_level_next != LVL_FULL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_s_data;
  end

  // Output sample register and underrun counter
  logic [31:0] r_tx_data;
  logic        r_tx_valid;
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_data      <= 32'd0;
      r_tx_valid     <= 1'b0;
      r_underrun_cnt <= 16'd0;
    end else begin
      r_tx_valid <= i_frame_req;
      if (i_frame_req) begin
        case (i_mode)
          2'd0:    r_tx_data <= 32'd0;
          2'd1:    r_tx_data <= w_tone;
          default: begin
            if (!w_empty)            r_tx_data <= r_mem[r_rptr];
            else if (i_mode == 2'd3) r_tx_data <= w_tone;
            else                     r_tx_data <= 32'd0;
          end
        endcase
      end
      if (w_underrun && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign o_s_ready      = r_s_ready;
  assign o_tx_data      = r_tx_data;
  assign o_tx_valid     = r_tx_valid;
  assign o_fifo_level   = r_level;
  assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_source_sched.sv
// Self-checking bench for i2s_source_sched: vector table for stream/backpressure,
// hand sequences for tone, underrun, flush and reset; tx samples go through a scoreboard.
module tb_i2s_source_sched;

  localparam int DEPTH = 4;
  localparam logic [31:0] HI = 32'h1FFF8FFF;
  localparam logic [31:0] LO = 32'h8FFF1FFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [23:0] tone_half;
  logic [31:0] tone_hi;
  logic [31:0] tone_lo;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        frame_req;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // Reference tone state as the DUT should hold it between edges
  int   m_tcnt  = 0;
  logic m_phase = 1'b0;

  always #5 clk = ~clk;

  i2s_source_sched #(.DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mode         (mode),
    .i_tone_half    (tone_half),
    .i_tone_hi      (tone_hi),
    .i_tone_lo      (tone_lo),
    .i_s_valid      (s_valid),
    .i_s_data       (s_data),
    .o_s_ready      (s_ready),
    .i_frame_req    (frame_req),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .o_fifo_level   (fifo_level),
    .o_underrun_cnt (underrun_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tone_now();
    return m_phase ? tone_lo : tone_hi;
  endfunction

  always @(posedge clk) begin
    int h;
    h = (tone_half == 24'd0) ? 1 : int'(tone_half);
    if (rst) begin
      m_tcnt  = 0;
      m_phase = 1'b0;
    end else if (m_tcnt >= h - 1) begin
      m_tcnt  = 0;
      m_phase = ~m_phase;
    end else begin
      m_tcnt  = m_tcnt + 1;
    end
  end

  // Scoreboard consumer
  always @(posedge clk) begin
    #1;
    if (tx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got tx_valid with data %08h, expected no frame", tx_data);
      end else begin
        chk("tx_data", tx_data, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        fr;
    logic [31:0] etx;
    int          elvl;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic sv, input logic [31:0] sd, input logic fr,
                         input logic [31:0] etx, input int elvl, input logic erdy);
    vec_t v;
    v.sv = sv; v.sd = sd; v.fr = fr; v.etx = etx; v.elvl = elvl; v.erdy = erdy;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; mode = 2'd1; tone_half = 24'd4; tone_hi = HI; tone_lo = LO;
    s_valid = 1'b0; s_data = 32'd0; frame_req = 1'b0;

    // Stream order/latency: A,B,C then three requests spaced 5 cycles
    add_vec(1, 32'hA0A0_0001, 0, 0, 1, 1);
    add_vec(1, 32'hB0B0_0002, 0, 0, 2, 1);
    add_vec(1, 32'hC0C0_0003, 0, 0, 3, 1);
    add_vec(0, 0, 1, 32'hA0A0_0001, 2, 1);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 2, 1);
    add_vec(0, 0, 1, 32'hB0B0_0002, 1, 1);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 1, 1);
    add_vec(0, 0, 1, 32'hC0C0_0003, 0, 1);
    // Full/backpressure with s_valid held high
    add_vec(1, 32'hD000_0000, 0, 0, 1, 1);
    add_vec(1, 32'hD000_0001, 0, 0, 2, 1);
    add_vec(1, 32'hD000_0002, 0, 0, 3, 1);
    add_vec(1, 32'hD000_0003, 0, 0, 4, 0);
    add_vec(1, 32'hD000_0004, 0, 0, 4, 0);
    add_vec(1, 32'hD000_0004, 0, 0, 4, 0);
    add_vec(1, 32'hD000_0004, 1, 32'hD000_0000, 3, 1);
    add_vec(1, 32'hD000_0004, 0, 0, 4, 0);
    add_vec(0, 0, 1, 32'hD000_0001, 3, 1);
    add_vec(0, 0, 1, 32'hD000_0002, 2, 1);
    add_vec(0, 0, 1, 32'hD000_0003, 1, 1);
    add_vec(0, 0, 1, 32'hD000_0004, 0, 1);

    // Reset state
    step(); step();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);

    // Tone: frame_req every cycle from the first cycle after release
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      frame_req = 1'b1;
      exp_q.push_back(((k / 4) % 2 == 1) ? LO : HI);
      step();
      chk("tone_tx_valid", 32'(tx_valid), 32'd1);
    end
    frame_req = 1'b0;
    step();
    chk("tone_valid_drop", 32'(tx_valid), 32'd0);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Stream and backpressure table
    mode = 2'd2;
    foreach (tbl[i]) begin
      s_valid = tbl[i].sv;
      s_data = tbl[i].sd;
      frame_req = tbl[i].fr;
      if (tbl[i].fr) exp_q.push_back(tbl[i].etx);
      step();
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].elvl));
      chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(tbl[i].fr));
    end
    s_valid = 1'b0; frame_req = 1'b0;
    step();
    chk("stream_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: zero in mode 2, tone in mode 3
    for (int k = 0; k < 3; k++) begin
      frame_req = 1'b1;
      exp_q.push_back(32'd0);
      step();
    end
    frame_req = 1'b0;
    step();
    chk("underrun_cnt3", 32'(underrun_cnt), 32'd3);
    mode = 2'd3;
    frame_req = 1'b1;
    exp_q.push_back(tone_now());
    step();
    frame_req = 1'b0;
    step();
    chk("underrun_cnt4", 32'(underrun_cnt), 32'd4);

    // Flush via mode 0
    mode = 2'd2;
    s_valid = 1'b1; s_data = 32'hE000_000E; step();
    s_data = 32'hF000_000F; step();
    s_valid = 1'b0;
    chk("flush_fill", 32'(fifo_level), 32'd2);
    mode = 2'd0; step();
    chk("flush_level", 32'(fifo_level), 32'd0);
    s_valid = 1'b1; s_data = 32'h1234_5678; step();
    s_valid = 1'b0;
    chk("flush_discard", 32'(fifo_level), 32'd0);
    chk("flush_ready", 32'(s_ready), 32'd1);
    frame_req = 1'b1;
    exp_q.push_back(32'd0);
    step();
    frame_req = 1'b0;
    step();
    chk("mode0_no_underrun", 32'(underrun_cnt), 32'd4);
    mode = 2'd2;
    frame_req = 1'b1;
    exp_q.push_back(32'd0);
    step();
    frame_req = 1'b0;
    step();
    chk("flush_underrun", 32'(underrun_cnt), 32'd5);

    // Reset mid-stream with a frame request in the reset cycle
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data = 32'h9000_0000 + 32'(k);
      step();
    end
    s_valid = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    rst = 1'b1; frame_req = 1'b1;
    step();
    chk("mrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mrst_tx_data", tx_data, 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_underrun", 32'(underrun_cnt), 32'd0);
    chk("mrst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0; frame_req = 1'b0;
    step();
    chk("rel_s_ready", 32'(s_ready), 32'd1);
    chk("rel_tx_valid", 32'(tx_valid), 32'd0);

    step(); step(); step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
